// File: rtl/snake_direction_ctrl_pkg.sv
// Shared definitions for the snake direction controller: movement control
// codes (also consumed by control_signal_mux and the movement logic), FSM
// state encoding, button indices and the reversal helper.
package snake_direction_ctrl_pkg;

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  localparam int NUM_BTN   = 5;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_PAUSE = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  // True when heading b would be a 180-degree turn from heading a.
  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
           ((a == DIR_DOWN) && (b == DIR_UP))    ||
           ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
           ((a == DIR_RIGHT) && (b == DIR_LEFT));
  endfunction

endpackage

// File: rtl/snake_direction_ctrl_button_debouncer.sv
// One push-button input path: two-flop synchronizer, stability counter and
// rising-edge press pulse on the debounced value.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; flip once it has persisted long enough.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchronizer, debounce state and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/snake_direction_ctrl.sv
// Player direction controller: debounced buttons feed a priority encoder and
// reversal filter; a pending heading is committed on the game tick.
module snake_direction_ctrl
  import snake_direction_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_pause,
  input  logic       tick,
  output logic [2:0] dir_out,
  output logic       dir_changed,
  output logic       paused
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;

  assign btn_raw = {btn_pause, btn_right, btn_left, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[gi]),
        .stable(),
        .press (btn_press[gi])
      );
    end
  endgenerate

  state_e     state_q, state_d;
  logic [2:0] dir_q, dir_d;
  logic [2:0] pend_q, pend_d;
  logic       chg_q;
  logic [2:0] req;
  logic       req_ok;

  // Priority encode simultaneous presses and filter against the committed heading.
  always_comb begin
    req = DIR_STOP;
    if (btn_press[BTN_UP])         req = DIR_UP;
    else if (btn_press[BTN_DOWN])  req = DIR_DOWN;
    else if (btn_press[BTN_LEFT])  req = DIR_LEFT;
    else if (btn_press[BTN_RIGHT]) req = DIR_RIGHT;
    req_ok = (req != DIR_STOP) && (req != dir_q) && !is_opposite(dir_q, req);
  end

  // Next state, commit on tick, pause toggling; a same-cycle request overrides pend.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && (pend_q != DIR_STOP)) begin
          dir_d   = pend_q;
          pend_d  = DIR_STOP;
          state_d = ST_MOVING;
        end
      end
      ST_MOVING: begin
        if (btn_press[BTN_PAUSE]) begin
          state_d = ST_PAUSED;
        end else if (tick && (pend_q != DIR_STOP)) begin
          dir_d  = pend_q;
          pend_d = DIR_STOP;
        end
      end
      ST_PAUSED: begin
        if (btn_press[BTN_PAUSE]) state_d = ST_MOVING;
      end
      default: state_d = ST_IDLE;
    endcase
    if (req_ok) pend_d = req;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_STOP;
      pend_q  <= DIR_STOP;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      chg_q   <= (dir_d != dir_q);
    end
  end

  assign dir_out     = dir_q;
  assign dir_changed = chg_q;
  assign paused      = (state_q == ST_PAUSED);

endmodule
